i2s_rx_tdm: RTL and testbench
=============================

Name: i2s_rx_tdm

Overview:
- Parametrised serial-audio receiver: deserialises stereo I2S or multi-slot TDM from the codec input pins into one packed parallel frame per sample period.
- Successor to the fixed 16-bit stereo receiver in the top-level input path.
- Adds configurable word width, slot width, channel count and framing mode, plus lock and framing-error reporting.
- Runs entirely in the sclk_i domain; downstream CDC/buffering consumes valid_o/data_o.

Parameters:
DATA_WIDTH, 16, captured bits per channel (MSB-first, two's complement); must be <= SLOT_WIDTH
SLOT_WIDTH, 16, serial bit periods per channel slot (e.g. 32 for padded codecs)
NUM_CH, 2, channels per frame; must be 2 when MODE=0, 2..8 when MODE=1
MODE, 0, 0 = I2S (ws level selects channel), 1 = TDM (one-bit ws pulse marks frame start)

Ports:
sclk_i  in  1  serial bit clock; all logic on posedge
rst_n_i  in  1  synchronous active-low reset, sampled on posedge sclk_i
ws_i  in  1  word select (MODE=0) / frame sync (MODE=1), driven on negedge
sdata_i  in  1  serial data, driven on negedge, sampled on posedge
data_o  out  NUM_CH*DATA_WIDTH  last good frame; channel c at [c*DATA_WIDTH +: DATA_WIDTH], ch0 = left
valid_o  out  1  one-cycle pulse, data_o updated with a new frame
locked_o  out  1  receiver aligned to frame boundaries
error_o  out  1  sticky framing error
err_count_o  out  8  framing errors, saturating at 255

Behaviour:
- Reset (rst_n_i=0 at posedge): data_o=0, valid_o=0, locked_o=0, error_o=0, err_count_o=0, state=SYNC, bit/slot counters=0, ws_q=0. Reset wins over every other event, mid-frame included; partial words are discarded.
- ws_q registers ws_i every cycle.
- Boundary event at posedge t. The bit sampled at t is the last bit of the current slot; the bit at t+1 is the MSB of the next slot (one-bit I2S delay in both modes).
  - MODE=0 boundary: ws_i != ws_q. Falling edge = frame start (next slot is ch0); rising edge = next slot is ch1.
  - MODE=1 boundary: ws_i=1 at posedge = frame start (next slot is ch0). Internal slot advance every SLOT_WIDTH bits after that.
- States:
  - SYNC: sdata ignored. The first frame-start event sets bit_idx=0, slot=0 for t+1, locked_o=1, state=RUN. No error is raised in SYNC.
  - RUN: each posedge samples sdata_i at bit_idx.
    - bit_idx < DATA_WIDTH: bit is shifted into the current word.
    - bit_idx >= DATA_WIDTH: bit is ignored (padding).
    - bit_idx == DATA_WIDTH-1: the word is committed to the slot's staging register.
    - bit_idx saturates at SLOT_WIDTH; extra bits before the next boundary are ignored (ws gaps are tolerated).
- Frame output: on the posedge committing slot NUM_CH-1 of an error-free frame, all staging words copy to data_o and valid_o=1 in the following cycle only. data_o holds until the next good frame. Latency: valid_o rises one sclk after the last data bit of the last channel.
- Framing errors. Each one sets error_o=1, increments err_count_o (saturating), discards the current frame (no valid_o), and makes the boundary that caused it a normal frame start or slot start. Conditions:
  - Short slot: a boundary arrives with fewer than DATA_WIDTH bits received in the current slot (count includes the boundary bit).
  - MODE=0: two consecutive same-direction slots are impossible by construction, so only short slot applies.
  - MODE=1: a frame-start pulse arrives before slot NUM_CH-1 has committed (early frame).
  - MODE=1: a ws pulse lasts more than one cycle; each extra high cycle counts as a short-slot error.
- locked_o: stays 1 once set; only reset clears it.
- error_o: cleared only by reset.
- Simultaneous events:
  - Commit of the last word and a boundary in the same cycle is legal (exact-length slot): frame is valid, next frame starts at t+1.
  - A short-slot error and a frame start in the same cycle: error counted once, new frame starts.

Test Plan:
- MODE=0, defaults: reset 3 cycles, then left=0x0AAA, right=0x0BBB as standard I2S (ws falls with prior LSB) -> locked_o=1 after first falling edge; exactly one valid_o pulse one sclk after right LSB; data_o=0x0BBB_0AAA; error_o=0.
- MODE=0: random bits with ws toggling before the first falling edge, then frame 0x0CCC/0x0DDD -> no valid_o before sync; data_o=0x0DDD_0CCC; error_o=0.
- MODE=0, SLOT_WIDTH=32: 32-bit slots left=0x1234_FFFF, right=0x8001_0000 -> data_o=0x8001_1234, padding ignored, one valid_o.
- MODE=0: ws edge after only 10 left bits -> error_o=1, err_count_o=1, no valid_o for that frame; next clean frame 0x0EEE/0x0FFF -> valid_o, data_o=0x0FFF_0EEE.
- MODE=1, NUM_CH=4: pulse then slots 0x1111, 0x2222, 0x3333, 0x4444 -> data_o=0x4444_3333_2222_1111, one valid_o. Then a pulse after 2 slots -> err_count_o=1, no valid_o.
- Reset asserted mid-right-channel -> next cycle all outputs 0, locked_o=0; a subsequent full frame re-locks and produces a correct valid_o.

Source files
------------

// File: rtl/i2s_rx_tdm_if.sv
// Pin-level serial audio inputs and parallel frame/status outputs of the I2S/TDM receiver.
interface i2s_rx_tdm_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2
);
  logic                         ws_i;
  logic                         sdata_i;
  logic [NUM_CH*DATA_WIDTH-1:0] data_o;
  logic                         valid_o;
  logic                         locked_o;
  logic                         error_o;
  logic [7:0]                   err_count_o;

  modport master (
    output ws_i, sdata_i,
    input  data_o, valid_o, locked_o, error_o, err_count_o
  );

  modport slave (
    input  ws_i, sdata_i,
    output data_o, valid_o, locked_o, error_o, err_count_o
  );
endinterface

// File: rtl/i2s_rx_tdm.sv
// Parametrised I2S / TDM serial audio receiver: deserialises one packed frame per sample period,
// with lock detection and sticky framing-error reporting, entirely in the bit-clock domain.
module i2s_rx_tdm #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int MODE       = 0
) (
  input  logic        sclk_i,
  input  logic        rst_n_i,
  i2s_rx_tdm_if.slave bus
);

  localparam int BW = $clog2(SLOT_WIDTH + 1);
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [BW-1:0] L_DW_M1  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] L_SW     = BW'(SLOT_WIDTH);
  localparam logic [BW-1:0] L_SW_M1  = BW'(SLOT_WIDTH - 1);
  localparam logic [BW-1:0] L_BIT1   = BW'(1);
  localparam logic [SW-1:0] L_LAST   = SW'(NUM_CH - 1);
  localparam logic [SW-1:0] L_SLOT1  = SW'(1);

  typedef enum logic {
    ST_SYNC,
    ST_RUN
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;

  logic                         r_ws_q;
  logic [BW-1:0]                r_bit_idx;
  logic [SW-1:0]                r_slot;
  logic [DATA_WIDTH-1:0]        r_shift;
  logic [DATA_WIDTH-1:0]        r_stage [NUM_CH];
  logic                         r_frame_bad;
  logic                         r_last_done;
  logic [NUM_CH*DATA_WIDTH-1:0] r_data;
  logic                         r_valid;
  logic                         r_locked;
  logic                         r_error;
  logic [7:0]                   r_err_cnt;

  logic                         w_frame_start;
  logic                         w_slot_start;
  logic                         w_commit;
  logic                         w_commit_last;
  logic                         w_short;
  logic                         w_early;
  logic                         w_err;
  logic                         w_emit;
  logic                         w_advance;
  logic [DATA_WIDTH-1:0]        w_word;

  always_ff @(posedge sclk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A boundary means the bit sampled now closes the current slot; the next bit is the next slot's MSB.
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_slot_start  = 1'b0;
    w_commit      = 1'b0;
    w_commit_last = 1'b0;
    w_short       = 1'b0;
    w_early       = 1'b0;
    w_err         = 1'b0;
    w_emit        = 1'b0;
    w_advance     = 1'b0;
    w_word        = DATA_WIDTH'({r_shift, bus.sdata_i});

    if (MODE == 0) begin
      w_frame_start = r_ws_q & ~bus.ws_i;
      w_slot_start  = ~r_ws_q & bus.ws_i;
    end else begin
      w_frame_start = bus.ws_i;
    end

    case (r_state)
      ST_SYNC: begin
        if (w_frame_start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_commit      = (r_bit_idx == L_DW_M1);
        w_commit_last = w_commit && (r_slot == L_LAST);
        w_short       = (w_frame_start | w_slot_start) && (r_bit_idx < L_DW_M1);
        w_early       = (MODE != 0) && w_frame_start && !(r_last_done || w_commit_last);
        w_err         = w_short | w_early;
        w_emit        = w_commit_last && !r_frame_bad && !w_err;
        w_advance     = (MODE != 0) && !w_frame_start && (r_bit_idx == L_SW_M1) &&
                        (r_slot != L_LAST);
      end
      default: begin
        w_state_nxt = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge sclk_i) begin
    if (!rst_n_i) begin
      r_ws_q      <= 1'b0;
      r_bit_idx   <= '0;
      r_slot      <= '0;
      r_shift     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_stage[c] <= '0;
      end
      r_frame_bad <= 1'b0;
      r_last_done <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_ws_q  <= bus.ws_i;
      r_valid <= 1'b0;

      if (r_state == ST_SYNC) begin
        if (w_frame_start) begin
          r_bit_idx   <= '0;
          r_slot      <= '0;
          r_frame_bad <= 1'b0;
          r_last_done <= 1'b0;
          r_locked    <= 1'b1;
        end
      end else begin
        if (r_bit_idx <= L_DW_M1) begin
          r_shift <= w_word;
        end
        if (w_commit) begin
          r_stage[r_slot] <= w_word;
        end
        if (w_commit_last) begin
          r_last_done <= 1'b1;
        end
        if (w_emit) begin
          for (int c = 0; c < NUM_CH; c++) begin
            r_data[c*DATA_WIDTH +: DATA_WIDTH] <= (c == NUM_CH - 1) ? w_word : r_stage[c];
          end
          r_valid <= 1'b1;
        end

        // An erroneous boundary still starts a slot/frame; only a mid-frame one poisons the frame.
        if (w_frame_start) begin
          r_bit_idx   <= '0;
          r_slot      <= '0;
          r_frame_bad <= 1'b0;
          r_last_done <= 1'b0;
        end else if (w_slot_start) begin
          r_bit_idx <= '0;
          r_slot    <= L_SLOT1;
          if (w_err) begin
            r_frame_bad <= 1'b1;
          end
        end else if (w_advance) begin
          r_bit_idx <= '0;
          r_slot    <= r_slot + L_SLOT1;
        end else if (r_bit_idx != L_SW) begin
          r_bit_idx <= r_bit_idx + L_BIT1;
        end

        if (w_err) begin
          r_error <= 1'b1;
          if (r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
          end
        end
      end
    end
  end

  assign bus.data_o      = r_data;
  assign bus.valid_o     = r_valid;
  assign bus.locked_o    = r_locked;
  assign bus.error_o     = r_error;
  assign bus.err_count_o = r_err_cnt;

endmodule

// File: tb/tb_i2s_rx_tdm.sv
// Scoreboard bench for i2s_rx_tdm: three instances (I2S 16-bit, I2S 32-bit slots, 4-channel TDM)
// driven with directed frames; expected frames are queued at issue time and popped on valid_o.
module tb_i2s_rx_tdm;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } expT;

  logic       sclk = 1'b0;
  logic       rstN = 1'b0;
  logic [2:0] ws   = '0;
  logic [2:0] sd   = '0;
  int         cyc  = 0;
  int         nCompared   = 0;
  int         nMismatched = 0;
  expT        q0[$];
  expT        q1[$];
  expT        q2[$];

  i2s_rx_tdm_if #(.DATA_WIDTH(16), .NUM_CH(2)) if0 ();
  i2s_rx_tdm_if #(.DATA_WIDTH(16), .NUM_CH(2)) if1 ();
  i2s_rx_tdm_if #(.DATA_WIDTH(16), .NUM_CH(4)) if2 ();

  assign if0.ws_i = ws[0];
  assign if0.sdata_i = sd[0];
  assign if1.ws_i = ws[1];
  assign if1.sdata_i = sd[1];
  assign if2.ws_i = ws[2];
  assign if2.sdata_i = sd[2];

  i2s_rx_tdm #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .NUM_CH(2), .MODE(0)) u0 (
    .sclk_i(sclk), .rst_n_i(rstN), .bus(if0));
  i2s_rx_tdm #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .NUM_CH(2), .MODE(0)) u1 (
    .sclk_i(sclk), .rst_n_i(rstN), .bus(if1));
  i2s_rx_tdm #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .NUM_CH(4), .MODE(1)) u2 (
    .sclk_i(sclk), .rst_n_i(rstN), .bus(if2));

  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    nCompared++;
    if (act !== expv) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic checkValid(input int d, input logic [63:0] act);
    expT e;
    int  n;
    n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL dut%0d unexpected valid: got data 0x%0h at cycle %0d, expected no pulse",
               d, act, cyc);
    end else begin
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      checkOutput($sformatf("dut%0d frame data", d), act, e.data);
      checkOutput($sformatf("dut%0d valid latency cycle", d), 64'(cyc), 64'(e.cyc));
    end
  endtask

  always @(negedge sclk) if (if0.valid_o === 1'b1) checkValid(0, 64'(if0.data_o));
  always @(negedge sclk) if (if1.valid_o === 1'b1) checkValid(1, 64'(if1.data_o));
  always @(negedge sclk) if (if2.valid_o === 1'b1) checkValid(2, if2.data_o);

  task automatic applyStimulus(input int d, input logic w, input logic s);
    @(negedge sclk);
    ws[d] = w;
    sd[d] = s;
  endtask

  // The expected pulse appears after the posedge that samples the bit just driven.
  task automatic pushExp(input int d, input logic [63:0] data);
    expT e;
    e.data = data;
    e.cyc  = cyc + 1;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic applyReset(input int n);
    @(negedge sclk);
    rstN = 1'b0;
    ws   = '0;
    sd   = '0;
    repeat (n) @(negedge sclk);
    rstN = 1'b1;
  endtask

  task automatic waitSample();
    @(posedge sclk);
    #1;
  endtask

  task automatic i2sPreamble(input int d);
    applyStimulus(d, 1'b1, 1'b0);
    applyStimulus(d, 1'b1, 1'b1);
    applyStimulus(d, 1'b0, 1'b0);
  endtask

  // Standard I2S: ws changes together with the last bit of the preceding slot.
  task automatic i2sFrame(input int d, input logic [31:0] left, input logic [31:0] right,
                          input int sw, input int dw, input int lenL,
                          input bit expectValid, input logic [63:0] expData);
    for (int i = 0; i < lenL; i++) begin
      applyStimulus(d, 1'(i == lenL - 1), left[sw-1-i]);
    end
    for (int i = 0; i < sw; i++) begin
      applyStimulus(d, 1'(i != sw - 1), right[sw-1-i]);
      if (expectValid && i == dw - 1) pushExp(d, expData);
    end
  endtask

  task automatic tdmFrame(input int nSlots, input logic [63:0] words,
                          input bit expectValid, input logic [63:0] expData);
    for (int s = 0; s < nSlots; s++) begin
      for (int i = 0; i < 16; i++) begin
        applyStimulus(2, 1'(s == nSlots - 1 && i == 15), words[s*16 + 15 - i]);
        if (expectValid && s == 3 && i == 15) pushExp(2, expData);
      end
    end
  endtask

  initial begin
    applyReset(3);
    checkOutput("reset data_o", 64'(if0.data_o), 64'h0);
    checkOutput("reset valid_o", 64'(if0.valid_o), 64'h0);
    checkOutput("reset locked_o", 64'(if0.locked_o), 64'h0);
    checkOutput("reset error_o", 64'(if0.error_o), 64'h0);
    checkOutput("reset err_count_o", 64'(if0.err_count_o), 64'h0);
    checkOutput("reset tdm locked_o", 64'(if2.locked_o), 64'h0);

    $display("[TB] I2S basic frame");
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 1'b1);
    waitSample();
    checkOutput("locked before falling ws", 64'(if0.locked_o), 64'h0);
    applyStimulus(0, 1'b0, 1'b0);
    waitSample();
    checkOutput("locked after falling ws", 64'(if0.locked_o), 64'h1);
    i2sFrame(0, 32'h0AAA, 32'h0BBB, 16, 16, 16, 1'b1, 64'h0BBB_0AAA);
    waitSample();
    checkOutput("basic data_o", 64'(if0.data_o), 64'h0BBB_0AAA);
    checkOutput("basic error_o", 64'(if0.error_o), 64'h0);

    $display("[TB] I2S short left slot");
    i2sFrame(0, 32'h0123, 32'h0456, 16, 16, 10, 1'b0, 64'h0);
    waitSample();
    checkOutput("short error_o", 64'(if0.error_o), 64'h1);
    checkOutput("short err_count_o", 64'(if0.err_count_o), 64'h1);
    checkOutput("short data_o held", 64'(if0.data_o), 64'h0BBB_0AAA);
    i2sFrame(0, 32'h0EEE, 32'h0FFF, 16, 16, 16, 1'b1, 64'h0FFF_0EEE);
    waitSample();
    checkOutput("recover err_count_o", 64'(if0.err_count_o), 64'h1);
    checkOutput("recover error_o sticky", 64'(if0.error_o), 64'h1);

    $display("[TB] I2S reset mid right channel");
    for (int i = 0; i < 16; i++) applyStimulus(0, 1'(i == 15), 1'(i % 3 == 0));
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b1, 1'b1);
    applyReset(1);
    checkOutput("midreset data_o", 64'(if0.data_o), 64'h0);
    checkOutput("midreset locked_o", 64'(if0.locked_o), 64'h0);
    checkOutput("midreset error_o", 64'(if0.error_o), 64'h0);
    checkOutput("midreset err_count_o", 64'(if0.err_count_o), 64'h0);
    i2sPreamble(0);
    i2sFrame(0, 32'h0123, 32'h0456, 16, 16, 16, 1'b1, 64'h0456_0123);
    waitSample();
    checkOutput("relock locked_o", 64'(if0.locked_o), 64'h1);

    $display("[TB] I2S garbage before sync");
    applyReset(2);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) applyStimulus(0, 1'b1, 1'($urandom_range(0, 1)));
    waitSample();
    checkOutput("garbage locked_o", 64'(if0.locked_o), 64'h0);
    checkOutput("garbage error_o", 64'(if0.error_o), 64'h0);
    applyStimulus(0, 1'b0, 1'($urandom_range(0, 1)));
    i2sFrame(0, 32'h0CCC, 32'h0DDD, 16, 16, 16, 1'b1, 64'h0DDD_0CCC);
    waitSample();
    checkOutput("garbage frame error_o", 64'(if0.error_o), 64'h0);

    $display("[TB] I2S 32-bit slots");
    applyReset(2);
    i2sPreamble(1);
    i2sFrame(1, 32'h1234_FFFF, 32'h8001_0000, 32, 16, 32, 1'b1, 64'h8001_1234);
    waitSample();
    checkOutput("wide data_o", 64'(if1.data_o), 64'h8001_1234);
    checkOutput("wide error_o", 64'(if1.error_o), 64'h0);

    $display("[TB] TDM four channels");
    applyReset(2);
    applyStimulus(2, 1'b1, 1'b0);
    tdmFrame(4, 64'h4444_3333_2222_1111, 1'b1, 64'h4444_3333_2222_1111);
    waitSample();
    checkOutput("tdm locked_o", 64'(if2.locked_o), 64'h1);
    checkOutput("tdm error_o", 64'(if2.error_o), 64'h0);
    tdmFrame(2, 64'h0000_0000_BEEF_CAFE, 1'b0, 64'h0);
    waitSample();
    checkOutput("tdm early err_count_o", 64'(if2.err_count_o), 64'h1);
    checkOutput("tdm early data_o held", if2.data_o, 64'h4444_3333_2222_1111);
    applyStimulus(2, 1'b1, 1'b0);
    tdmFrame(4, 64'h8000_7FFF_00FF_0F0F, 1'b1, 64'h8000_7FFF_00FF_0F0F);
    waitSample();
    checkOutput("tdm long pulse err_count_o", 64'(if2.err_count_o), 64'h2);

    repeat (4) @(negedge sclk);
    checkOutput("dut0 frames outstanding", 64'(q0.size()), 64'h0);
    checkOutput("dut1 frames outstanding", 64'(q1.size()), 64'h0);
    checkOutput("dut2 frames outstanding", 64'(q2.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
